// File: rtl/bf_program_loader.sv
// bf_program_loader
//   Loads a brainfuck program from the UART receiver into the code RAM while
//   holding the core in reset. It then releases the core and supervises it
//   until it finishes or the watchdog expires, and parks until a reload is
//   requested.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   rx_valid    one-cycle strobe: rx_data holds a received byte
//   rx_data     received byte
//   load_rq     level: requests a new program load while parked in DONE
//   core_done   done flag from the core
//   code_we     code RAM write enable (single-cycle pulse per write)
//   code_addr   code RAM write address
//   code_wdata  code RAM write data
//   core_run    core reset input (active-low at the core): 0 holds it, 1 runs it
//   prog_len    number of instructions stored, not counting the terminator
//   overflow    program was truncated to fit the RAM
//   timeout     watchdog expired
//   state       LOAD=0, START=1, RUN=2, DONE=3
module bf_program_loader #(
    parameter int unsigned CODE_ADDR_WIDTH = 9,
    parameter logic [7:0]  END_CHAR        = 8'h00,
    parameter bit          FILTER          = 1'b1,
    parameter int unsigned TIMEOUT         = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       load_rq,
    input  logic                       core_done,
    output logic                       code_we,
    output logic [CODE_ADDR_WIDTH-1:0] code_addr,
    output logic [7:0]                 code_wdata,
    output logic                       core_run,
    output logic [CODE_ADDR_WIDTH-1:0] prog_len,
    output logic                       overflow,
    output logic                       timeout,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam logic [CODE_ADDR_WIDTH-1:0] ADDR_ONE = CODE_ADDR_WIDTH'(1);

    // Watchdog fires when the count of completed RUN cycles reaches TIMEOUT-1.
    // With TIMEOUT=0 the limit is unused; the ternary only keeps it well defined.
    localparam logic [31:0] WD_LIMIT = (TIMEOUT == 0) ? '1 : 32'(TIMEOUT - 1);

    state_t                     st;
    logic [CODE_ADDR_WIDTH-1:0] wr_ptr;
    logic [31:0]                wd_cnt;
    logic                       is_cmd;
    logic                       accept;

    // A byte is accepted if filtering is off, or it is one of the eight
    // brainfuck commands, or it is the terminator.
    always_comb begin
        is_cmd = 1'b0;
        case (rx_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E,
            8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default:                    is_cmd = 1'b0;
        endcase
        accept = !FILTER || is_cmd || (rx_data == END_CHAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_LOAD;
            wr_ptr     <= '0;
            wd_cnt     <= '0;
            code_we    <= 1'b0;
            code_addr  <= '0;
            code_wdata <= '0;
            core_run   <= 1'b0;
            prog_len   <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            code_we <= 1'b0;
            case (st)
                S_LOAD: begin
                    core_run <= 1'b0;
                    if (rx_valid && accept) begin
                        code_we   <= 1'b1;
                        code_addr <= wr_ptr;
                        if (rx_data == END_CHAR) begin
                            code_wdata <= END_CHAR;
                            prog_len   <= wr_ptr;
                            st         <= S_START;
                        end else if (wr_ptr == '1) begin
                            // Last slot is reserved for the terminator: truncate here.
                            code_wdata <= END_CHAR;
                            overflow   <= 1'b1;
                            prog_len   <= wr_ptr;
                            st         <= S_START;
                        end else begin
                            code_wdata <= rx_data;
                            wr_ptr     <= wr_ptr + ADDR_ONE;
                        end
                    end
                end
                S_START: begin
                    // core_run was 0 during this cycle, guaranteeing one reset
                    // cycle after the final RAM write.
                    wd_cnt   <= '0;
                    core_run <= 1'b1;
                    st       <= S_RUN;
                end
                S_RUN: begin
                    if (wd_cnt != '1)
                        wd_cnt <= wd_cnt + 32'd1;
                    if (core_done) begin
                        st <= S_DONE;
                    end else if (TIMEOUT != 0 && wd_cnt >= WD_LIMIT) begin
                        timeout  <= 1'b1;
                        core_run <= 1'b0;
                        st       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (load_rq) begin
                        st       <= S_LOAD;
                        wr_ptr   <= '0;
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                        prog_len <= '0;
                        core_run <= 1'b0;
                    end
                end
                default: begin
                    st       <= S_LOAD;
                    core_run <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_bf_program_loader.sv
`timescale 1ns/1ps
module tb_bf_program_loader;

    localparam int         W     = 3;
    localparam int         CAP   = 1 << W;
    localparam logic [7:0] END_B = 8'h00;
    localparam int         TO    = 20;

    localparam int S_LOAD = 0, S_START = 1, S_RUN = 2, S_DONE = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [W-1:0] addr;
        logic [7:0]   data;
    } wr_t;

    logic         clk = 1'b0;
    logic         reset, rx_valid, load_rq, core_done;
    logic [7:0]   rx_data;
    logic         code_we;
    logic [W-1:0] code_addr;
    logic [7:0]   code_wdata;
    logic         core_run;
    logic [W-1:0] prog_len;
    logic         overflow, timeout;
    logic [2:0]   state;

    int n_cmp = 0;
    int n_bad = 0;
    wr_t exp_q[$];

    // Behavioural model: program-level state of the loader.
    int m_state, m_ptr, m_len, m_runcyc;
    bit m_ovf, m_to, m_run;

    bf_program_loader #(
        .CODE_ADDR_WIDTH(W),
        .END_CHAR(END_B),
        .FILTER(1'b1),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .load_rq(load_rq), .core_done(core_done),
        .code_we(code_we), .code_addr(code_addr), .code_wdata(code_wdata),
        .core_run(core_run), .prog_len(prog_len), .overflow(overflow),
        .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish, required finish before 500000ns");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every code_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (code_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %02h, expected no write (t=%0t)",
                         code_addr, code_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(code_addr), 32'(e.addr));
                check("write_data", 32'(code_wdata), 32'(e.data));
            end
        end
    end

    function automatic bit is_cmd(input logic [7:0] b);
        return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
    endfunction

    task automatic model_reset();
        m_state = S_LOAD; m_ptr = 0; m_len = 0; m_runcyc = 0;
        m_ovf = 0; m_to = 0; m_run = 0;
        exp_q.delete();
    endtask

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = W'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock edge of the loader, described at program level.
    task automatic model_edge(input bit v, input logic [7:0] b, input bit lq, input bit cd);
        case (m_state)
            S_LOAD: begin
                if (v && (is_cmd(b) || b == END_B)) begin
                    if (b == END_B) begin
                        push_wr(m_ptr, END_B);
                        m_len = m_ptr;
                        m_state = S_START;
                    end else if (m_ptr == CAP - 1) begin
                        push_wr(m_ptr, END_B);
                        m_ovf = 1;
                        m_len = CAP - 1;
                        m_state = S_START;
                    end else begin
                        push_wr(m_ptr, b);
                        m_ptr++;
                    end
                end
            end
            S_START: begin
                m_state = S_RUN;
                m_run = 1;
                m_runcyc = 1;
            end
            S_RUN: begin
                if (cd) begin
                    m_state = S_DONE;
                end else if (m_runcyc == TO) begin
                    m_to = 1;
                    m_run = 0;
                    m_state = S_DONE;
                end else begin
                    m_runcyc++;
                end
            end
            default: begin
                if (lq) begin
                    m_state = S_LOAD;
                    m_ptr = 0; m_len = 0; m_ovf = 0; m_to = 0; m_run = 0;
                end
            end
        endcase
    endtask

    task automatic check_status();
        check("state", 32'(state), 32'(m_state));
        check("core_run", 32'(core_run), 32'(m_run));
        check("prog_len", 32'(prog_len), 32'(m_len));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("timeout", 32'(timeout), 32'(m_to));
        check("write_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit lq, input bit cd);
        rx_valid = v; rx_data = b; load_rq = lq; core_done = cd;
        model_edge(v, b, lq, cd);
        @(negedge clk); #1;
        rx_valid = 1'b0; load_rq = 1'b0;
        check_status();
    endtask

    function automatic bq_t prog_of(input string s, input bit term);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        if (term) q.push_back(END_B);
        return q;
    endfunction

    task automatic load_program(input bq_t prog, input int max_gap);
        for (int i = 0; i < prog.size(); i++) begin
            step(1'b1, prog[i], 1'b0, 1'b0);
            repeat ($urandom_range(0, max_gap)) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        end
    endtask

    // Steps until DONE; core_done rises on RUN cycle done_at (0 = never).
    task automatic run_phase(input int done_at);
        int cyc = 0;
        for (int k = 0; k < TO + 8 && m_state != S_DONE; k++) begin
            if (m_state == S_RUN) cyc++;
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 done_at != 0 && cyc >= done_at);
        end
        check("reached_done", 32'(m_state), 32'(S_DONE));
    endtask

    task automatic idle_done(input int n);
        repeat (n) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic reload();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_code_we", 32'(code_we), 32'd0);
        check("rst_code_addr", 32'(code_addr), 32'd0);
        check("rst_code_wdata", 32'(code_wdata), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_state", 32'(state), 32'(S_LOAD));
    endtask

    initial begin
        bq_t p;
        logic [7:0] cmds [8] = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
        logic [7:0] b;

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; load_rq = 1'b0; core_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // Basic program, normal finish, reload.
        load_program(prog_of("+[-]", 1'b1), 0);
        run_phase(5);
        idle_done(2);
        reload();

        // Filtered bytes produce no writes and leave the pointer alone.
        load_program(prog_of("+a\n.", 1'b1), 1);
        run_phase(3);
        reload();

        // Overflow: nine commands into an eight-byte RAM.
        p = {};
        repeat (9) p.push_back(8'h2B);
        load_program(p, 0);
        run_phase(4);
        reload();

        // Watchdog expiry, then done arriving on the expiry cycle.
        load_program(prog_of("+.", 1'b1), 0);
        run_phase(0);
        idle_done(2);
        reload();
        load_program(prog_of(",", 1'b1), 0);
        run_phase(TO);
        idle_done(1);
        reload();

        // Random programs.
        for (int it = 0; it < 40; it++) begin
            p = {};
            repeat ($urandom_range(0, CAP + 1)) begin
                if ($urandom_range(0, 9) < 7) begin
                    b = cmds[$urandom_range(0, 7)];
                end else begin
                    do b = 8'($urandom); while (is_cmd(b) || b == END_B);
                end
                p.push_back(b);
            end
            p.push_back(END_B);
            load_program(p, 2);
            run_phase($urandom_range(0, TO + 3));
            idle_done($urandom_range(0, 2));
            reload();
        end

        // Asynchronous reset in the middle of RUN.
        load_program(prog_of("+[-]", 1'b1), 0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_reset_run", 32'(m_state), 32'(S_RUN));
        #2 reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        load_program(prog_of("><", 1'b1), 0);
        run_phase(2);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bf_program_loader.md
Name: bf_program_loader

Overview:
- Sequences the brainfuck core: streams program bytes from the UART receiver into the code RAM, holds the core in reset while loading, then releases it and supervises execution.
- Sits between the UART RX, the code RAM write port and the core's reset/done signals.
- On completion or watchdog timeout it parks, then reloads on request.

Parameters:
CODE_ADDR_WIDTH, 9, code RAM address width; capacity 2^CODE_ADDR_WIDTH bytes.
END_CHAR, 8'h00, program terminator byte; it is always written after the last instruction.
FILTER, 1, when 1, RX bytes other than + - < > [ ] . , and END_CHAR are discarded.
TIMEOUT, 0, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx_valid  input  1  one-cycle strobe; rx_data is valid
rx_data  input  8  received byte
load_rq  input  1  level; requests a new program load from DONE
core_done  input  1  core's done flag
code_we  output  1  code RAM write enable
code_addr  output  CODE_ADDR_WIDTH  code RAM write address
code_wdata  output  8  code RAM write data
core_run  output  1  drives the core reset input (core reset is active-low): 0 holds the core in reset, 1 runs it
prog_len  output  CODE_ADDR_WIDTH  instructions stored, excluding the terminator
overflow  output  1  program was truncated to fit the RAM
timeout  output  1  watchdog expired
state  output  3  LOAD=0, START=1, RUN=2, DONE=3

Behaviour:
- Reset (async, active-high) forces: state=LOAD, code_we=0, code_addr=0, code_wdata=0, core_run=0, prog_len=0, overflow=0, timeout=0, watchdog counter=0.
- All outputs are registered. A write appears on code_* the cycle after the accepted rx_valid, as a single-cycle code_we pulse.

LOAD:
- core_run=0. Each rx_valid with an accepted byte writes it at wr_ptr, then increments wr_ptr.
- A filtered byte (FILTER=1) produces no write and leaves wr_ptr unchanged.
- Receiving END_CHAR writes END_CHAR at wr_ptr, sets prog_len=wr_ptr and moves to START.
- Full case: an accepted non-terminator byte arriving at wr_ptr = 2^W-1 writes END_CHAR instead of the byte, sets overflow=1, prog_len=2^W-1 and moves to START.
- rx_valid outside LOAD is ignored.

START:
- One cycle. core_run stays 0 and the watchdog is cleared; the core thereby sees at least one reset cycle after the final write.
- Next state: RUN.

RUN:
- core_run=1 and the watchdog increments every cycle.
- core_done=1 moves to DONE.
- If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without core_done, set timeout=1 and move to DONE. If core_done arrives in the same cycle, done wins and timeout stays 0.

DONE:
- core_run=1 after a normal finish, so the core holds its done state.
- After a timeout, core_run=0, which freezes the core.
- load_rq=1 moves to LOAD with wr_ptr=0, and overflow, timeout and prog_len cleared; core_run=0 from that cycle.

General rules:
- load_rq in any state other than DONE is ignored.
- Asserting reset mid-load or mid-run aborts immediately with reset values. RAM contents already written are not cleared.
- The watchdog counter is 32 bits wide and saturates; it never wraps.

Test Plan:
- Reset, then RX "+[-]" followed by 8'h00 → writes addr 0..4 = '+','[','-',']',00; prog_len=4; state LOAD→START→RUN; core_run rises exactly 2 cycles after the 00 byte is accepted.
- FILTER=1, RX "+a\n." then 00 → only '+' at 0, '.' at 1 and 00 at 2; prog_len=2; no code_we pulse for 'a' or '\n'.
- CODE_ADDR_WIDTH=3, RX 9 '+' bytes → addr 0..6 = '+', addr 7 = 00; overflow=1; prog_len=7; the 9th byte is ignored because state is no longer LOAD.
- Run, then assert core_done → state=DONE with core_run=1; pulse load_rq → state=LOAD, core_run=0, prog_len=0, and the next byte is written at addr 0.
- TIMEOUT=20, core_done held 0 → timeout=1 and state=DONE on RUN cycle 20, core_run=0. Repeat with core_done rising on that same cycle → timeout=0.
- Assert reset in the middle of a RUN → all outputs return to reset values asynchronously; after release, state=LOAD.
